// File: rtl/e_mdu_if.sv
// E-stage multiply/divide unit bus.
// The master (E-stage datapath) drives en/A/B/MDUOp. The slave (e_mdu) returns
// Start, Busy and MDUOut.
//   en      : E-stage instruction valid (0 = bubble)
//   A, B    : forwarded rs / rt operands
//   MDUOp   : MDU operation code
//   Start   : a mult/div is being launched this cycle
//   Busy    : a mult/div is in flight
//   MDUOut  : committed HI/LO for mfhi/mflo, else 0
interface e_mdu_if;
  logic        en;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  MDUOp;
  logic        Start;
  logic        Busy;
  logic [31:0] MDUOut;

  modport master (output en, A, B, MDUOp, input Start, Busy, MDUOut);
  modport slave  (input en, A, B, MDUOp, output Start, Busy, MDUOut);
endinterface

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit. It owns the HI/LO pair and models
// multi-cycle mult/div latency. The result is computed at launch, held pending,
// and committed to HI/LO when the busy countdown expires.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-high
//   mdu_if : slave side of e_mdu_if (en, A, B, MDUOp in; Start, Busy, MDUOut out)
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic     clk,
  input logic     reset,
  e_mdu_if.slave  mdu_if
);

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMfhi  = 4'd5;
  localparam logic [3:0] OpMflo  = 4'd6;
  localparam logic [3:0] OpMthi  = 4'd7;
  localparam logic [3:0] OpMtlo  = 4'd8;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e      state_q;
  logic [31:0] hi_q, lo_q, res_hi_q, res_lo_q;
  logic [3:0]  cnt_q;
  logic        div0_q;  // pending divide-by-zero: countdown runs but nothing commits

  logic [3:0]  op;
  logic        is_mul, is_div, start;
  logic        sgn;
  logic [63:0] mul_a, mul_b, product;
  logic [31:0] a_mag, b_mag, dividend, divisor, quot, rem;
  logic [31:0] div_lo, div_hi;

  assign op     = mdu_if.MDUOp;
  assign is_mul = mdu_if.en && (op == OpMult || op == OpMultu);
  assign is_div = mdu_if.en && (op == OpDiv || op == OpDivu);
  assign start  = is_mul || is_div;
  assign sgn    = (op == OpMult) || (op == OpDiv);

  // One shared multiplier and one shared divider for both signednesses.
  always_comb begin
    mul_a   = {{32{sgn & mdu_if.A[31]}}, mdu_if.A};
    mul_b   = {{32{sgn & mdu_if.B[31]}}, mdu_if.B};
    product = mul_a * mul_b;

    // Magnitudes as unsigned; 0x80000000 maps to 2^31, so signed overflow
    // falls out as quotient 0x80000000, remainder 0.
    a_mag    = mdu_if.A[31] ? -mdu_if.A : mdu_if.A;
    b_mag    = mdu_if.B[31] ? -mdu_if.B : mdu_if.B;
    dividend = sgn ? a_mag : mdu_if.A;
    divisor  = sgn ? b_mag : mdu_if.B;
    // Divisor forced nonzero so the divider never sees 0; the result is
    // discarded via div0_q in that case.
    if (divisor == 32'd0) divisor = 32'd1;
    quot = dividend / divisor;
    rem  = dividend % divisor;

    div_lo = quot;
    div_hi = rem;
    if (sgn) begin
      if (mdu_if.A[31] ^ mdu_if.B[31]) div_lo = -quot;
      if (mdu_if.A[31])                div_hi = -rem;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      hi_q     <= '0;
      lo_q     <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      cnt_q    <= '0;
      div0_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (is_mul) begin
              res_hi_q <= product[63:32];
              res_lo_q <= product[31:0];
              cnt_q    <= 4'(MULT_CYCLES);
              div0_q   <= 1'b0;
            end else begin
              res_hi_q <= div_hi;
              res_lo_q <= div_lo;
              cnt_q    <= 4'(DIV_CYCLES);
              div0_q   <= (mdu_if.B == 32'd0);
            end
            state_q <= StRun;
          end else if (mdu_if.en && op == OpMthi) begin
            hi_q <= mdu_if.A;
          end else if (mdu_if.en && op == OpMtlo) begin
            lo_q <= mdu_if.A;
          end
        end
        StRun: begin
          // Countdown ignores en; new ops arriving here are dropped.
          if (cnt_q == 4'd1) begin
            if (!div0_q) begin
              hi_q <= res_hi_q;
              lo_q <= res_lo_q;
            end
            cnt_q   <= '0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mdu_if.Start = start;
  assign mdu_if.Busy  = (state_q == StRun);

  always_comb begin
    mdu_if.MDUOut = '0;
    if (op == OpMfhi)      mdu_if.MDUOut = hi_q;
    else if (op == OpMflo) mdu_if.MDUOut = lo_q;
  end

endmodule

// File: tb/tb_e_mdu.sv
module tb_e_mdu;

  localparam logic [3:0] OpNone  = 4'd0;
  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMfhi  = 4'd5;
  localparam logic [3:0] OpMflo  = 4'd6;
  localparam logic [3:0] OpMthi  = 4'd7;
  localparam logic [3:0] OpMtlo  = 4'd8;

  logic clk = 1'b0;
  logic reset;
  e_mdu_if bus ();

  e_mdu dut (.clk(clk), .reset(reset), .mdu_if(bus));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference HI/LO, updated only by ops that take effect.
  logic [31:0] m_hi, m_lo;

  // Architectural effect of a launched op, computed with wide integer arithmetic.
  task automatic model_apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sq, sr, sp;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      OpMult:  begin sp = sa * sb; m_hi = sp[63:32]; m_lo = sp[31:0]; end
      OpMultu: begin up = ua * ub; m_hi = up[63:32]; m_lo = up[31:0]; end
      OpDiv:   if (b != 0) begin
                 sq = sa / sb; sr = sa % sb; m_lo = sq[31:0]; m_hi = sr[31:0];
               end
      OpDivu:  if (b != 0) begin m_lo = 32'(ua / ub); m_hi = 32'(ua % ub); end
      OpMthi:  m_hi = a;
      OpMtlo:  m_lo = a;
      default: ;
    endcase
  endtask

  function automatic int model_busy(input logic [3:0] op);
    if (op == OpMult || op == OpMultu) return 5;
    if (op == OpDiv || op == OpDivu) return 10;
    return 0;
  endfunction

  // All helpers are entered and left in the low phase, just after a negedge.
  task automatic idle_inputs();
    bus.en = 1'b0; bus.A = '0; bus.B = '0; bus.MDUOp = OpNone;
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    bus.en = 1'b1; bus.MDUOp = OpMfhi; #1 hi = bus.MDUOut;
    bus.MDUOp = OpMflo; #1 lo = bus.MDUOut;
    idle_inputs();
  endtask

  // Drives op in cycle 0, then counts Busy cycles from cycle 1 onward. Returns
  // in the first cycle with Busy=0 (bounded at 30).
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic start0, output logic busy0, output int blen);
    bus.en = 1'b1; bus.A = a; bus.B = b; bus.MDUOp = op;
    #1 start0 = bus.Start; busy0 = bus.Busy;
    blen = 0;
    @(negedge clk);
    idle_inputs();
    for (int i = 0; i < 30; i++) begin
      if (!bus.Busy) break;
      blen++;
      @(negedge clk);
    end
  endtask

  task automatic do_mt(input logic [3:0] op, input logic [31:0] a);
    bus.en = 1'b1; bus.A = a; bus.MDUOp = op;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
  endtask

  task automatic test_reset();
    logic [31:0] hi, lo;
    apply_reset();
    read_hilo(hi, lo);
    n_cmp++; if (hi !== 32'h0) begin n_err++; $display("FAIL reset_hi: got %h want %h", hi, 32'h0); end
    n_cmp++; if (lo !== 32'h0) begin n_err++; $display("FAIL reset_lo: got %h want %h", lo, 32'h0); end
    n_cmp++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.Busy); end
  endtask

  // Launch op, check Start/Busy timing and committed HI/LO against the model.
  task automatic check_op(input string name, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b);
    logic s0, b0;
    int blen;
    logic [31:0] hi, lo;
    issue(op, a, b, s0, b0, blen);
    model_apply(op, a, b);
    read_hilo(hi, lo);
    n_cmp++; if (s0 !== 1'b1 || b0 !== 1'b0) begin
      n_err++; $display("FAIL %s_cycle0: start=%b busy=%b want start=1 busy=0", name, s0, b0);
    end
    n_cmp++; if (blen != model_busy(op)) begin
      n_err++; $display("FAIL %s_busylen: got %0d want %0d", name, blen, model_busy(op));
    end
    n_cmp++; if (hi !== m_hi) begin n_err++; $display("FAIL %s_hi: got %h want %h", name, hi, m_hi); end
    n_cmp++; if (lo !== m_lo) begin n_err++; $display("FAIL %s_lo: got %h want %h", name, lo, m_lo); end
  endtask

  task automatic test_mult();
    check_op("mult", OpMult, 32'hFFFFFFFF, 32'd2);
    n_cmp++; if (m_hi !== 32'hFFFFFFFF || m_lo !== 32'hFFFFFFFE) begin
      n_err++; $display("FAIL mult_model: got %h_%h want ffffffff_fffffffe", m_hi, m_lo);
    end
    check_op("multu", OpMultu, 32'hFFFFFFFF, 32'd2);
  endtask

  task automatic test_div();
    check_op("div", OpDiv, 32'hFFFFFFF9, 32'd2);
    check_op("divu", OpDivu, 32'd7, 32'd2);
    check_op("div_ovf", OpDiv, 32'h80000000, 32'hFFFFFFFF);
  endtask

  task automatic test_div_zero();
    logic [31:0] hi, lo;
    do_mt(OpMthi, 32'h1234); model_apply(OpMthi, 32'h1234, 0);
    read_hilo(hi, lo);
    n_cmp++; if (hi !== 32'h1234) begin n_err++; $display("FAIL mthi_next: got %h want %h", hi, 32'h1234); end
    do_mt(OpMtlo, 32'h5678); model_apply(OpMtlo, 32'h5678, 0);
    check_op("divu0", OpDivu, 32'd7, 32'd0);
    check_op("div0", OpDiv, 32'hFFFF0000, 32'd0);
  endtask

  task automatic test_reset_mid();
    logic s0, b0;
    logic [31:0] hi, lo;
    int late_busy;
    apply_reset();
    bus.en = 1'b1; bus.A = 32'h1234_5678; bus.B = 32'd3; bus.MDUOp = OpMult;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);          // cycle 2
    @(negedge clk);          // cycle 3
    reset = 1'b1;
    @(negedge clk);          // cycle 4
    reset = 1'b0;
    n_cmp++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", bus.Busy); end
    late_busy = 0;
    repeat (8) begin @(negedge clk); if (bus.Busy) late_busy++; end
    read_hilo(hi, lo);
    n_cmp++; if (late_busy != 0) begin n_err++; $display("FAIL rstmid_late_busy: got %0d want 0", late_busy); end
    n_cmp++; if (hi !== 32'h0 || lo !== 32'h0) begin
      n_err++; $display("FAIL rstmid_hilo: got %h_%h want 0_0", hi, lo);
    end
  endtask

  task automatic test_ignored();
    logic [31:0] hi, lo;
    int blen;
    do_mt(OpMthi, 32'hAAAA0001); model_apply(OpMthi, 32'hAAAA0001, 0);
    do_mt(OpMtlo, 32'hBBBB0002); model_apply(OpMtlo, 32'hBBBB0002, 0);
    // Divide by zero leaves HI/LO alone, so any write during Busy would show.
    bus.en = 1'b1; bus.A = 32'd9; bus.B = 32'd0; bus.MDUOp = OpDivu;
    @(negedge clk);          // cycle 1
    bus.A = 32'hDEADBEEF; bus.MDUOp = OpMtlo;
    @(negedge clk);          // cycle 2
    bus.MDUOp = OpMthi;
    @(negedge clk);          // cycle 3
    bus.A = 32'h7; bus.B = 32'h3; bus.MDUOp = OpMult;
    @(negedge clk);          // cycle 4
    idle_inputs();
    blen = 3;
    for (int i = 0; i < 30; i++) begin
      if (!bus.Busy) break;
      blen++;
      @(negedge clk);
    end
    read_hilo(hi, lo);
    n_cmp++; if (blen != 10) begin n_err++; $display("FAIL ign_busylen: got %0d want 10", blen); end
    n_cmp++; if (lo !== m_lo) begin n_err++; $display("FAIL ign_lo: got %h want %h", lo, m_lo); end
    n_cmp++; if (hi !== m_hi) begin n_err++; $display("FAIL ign_hi: got %h want %h", hi, m_hi); end
  endtask

  task automatic test_en_low();
    logic [31:0] hi, lo;
    logic st;
    bus.en = 1'b0; bus.A = 32'd5; bus.B = 32'd6; bus.MDUOp = OpMult;
    #1 st = bus.Start;
    @(negedge clk);
    n_cmp++; if (st !== 1'b0) begin n_err++; $display("FAIL enlow_start: got %b want 0", st); end
    n_cmp++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL enlow_busy: got %b want 0", bus.Busy); end
    bus.MDUOp = OpMthi;
    @(negedge clk);
    read_hilo(hi, lo);
    n_cmp++; if (hi !== m_hi || lo !== m_lo) begin
      n_err++; $display("FAIL enlow_hilo: got %h_%h want %h_%h", hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] hi, lo;
    check_op("b2b_first", OpMult, 32'h0001_0000, 32'h0003_0000);
    // Still in the first Busy=0 cycle: launch again immediately.
    check_op("b2b_second", OpMultu, 32'h8000_0001, 32'hFFFF_FFFF);
    check_op("b2b_third", OpDiv, 32'h0000_0064, 32'hFFFF_FFF9);
    read_hilo(hi, lo);
    n_cmp++; if (lo !== 32'hFFFFFFF2) begin n_err++; $display("FAIL b2b_quot: got %h want fffffff2", lo); end
  endtask

  task automatic test_random();
    logic [3:0] ops [6];
    logic [3:0] op;
    logic [31:0] a, b, hi, lo;
    ops = '{OpMult, OpMultu, OpDiv, OpDivu, OpMthi, OpMtlo};
    for (int i = 0; i < 30; i++) begin
      op = ops[$urandom_range(0, 5)];
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 9) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
      if (op == OpMthi || op == OpMtlo) begin
        do_mt(op, a);
        model_apply(op, a, b);
        read_hilo(hi, lo);
        n_cmp++; if (hi !== m_hi || lo !== m_lo) begin
          n_err++; $display("FAIL rand_mt[%0d]: got %h_%h want %h_%h", i, hi, lo, m_hi, m_lo);
        end
      end else begin
        check_op($sformatf("rand[%0d]", i), op, a, b);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_reset_mid();
    test_ignored();
    test_en_low();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
